// File: rtl/exp_sweep_ctrl.sv
// rtl/exp_sweep_ctrl.sv - truth-table sweep and compare controller for a small boolean datapath
module exp_sweep_ctrl #(
    parameter  int N_IN  = 3,
    parameter  int DWELL = 2,
    localparam int TW    = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [TW-1:0]   expected,
    output logic [N_IN-1:0] vec_o,
    input  logic            y_i,
    output logic            busy,
    output logic            done,
    output logic [TW-1:0]   table_o,
    output logic            pass,
    output logic [N_IN-1:0] fail_idx
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [7:0]      DW_LAST  = 8'(DWELL - 1);
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(TW - 1);

    state_t          r_state;
    logic [N_IN-1:0] r_vec;
    logic [7:0]      r_dwell;
    logic [TW-1:0]   r_table;
    logic [TW-1:0]   r_exp;
    logic            r_done;
    logic            r_pass;
    logic [N_IN-1:0] r_fail_idx;

    state_t          w_state_nxt;
    logic [N_IN-1:0] w_vec_nxt;
    logic [7:0]      w_dwell_nxt;
    logic [TW-1:0]   w_table_nxt;
    logic [TW-1:0]   w_exp_nxt;
    logic            w_done_nxt;
    logic            w_pass_nxt;
    logic [N_IN-1:0] w_fail_idx_nxt;
    logic [TW-1:0]   w_table_smp;
    logic [TW-1:0]   w_diff;
    logic [N_IN-1:0] w_first_miss;

    // Table as it will look once this edge's sample lands; pass/fail_idx judge this.
    always_comb begin
        w_table_smp        = r_table;
        w_table_smp[r_vec] = y_i;
    end

    assign w_diff = w_table_smp ^ r_exp;

    always_comb begin
        w_first_miss = '0;
        for (int i = TW - 1; i >= 0; i--) begin
            if (w_diff[i]) w_first_miss = N_IN'(i);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_vec_nxt      = r_vec;
        w_dwell_nxt    = r_dwell;
        w_table_nxt    = r_table;
        w_exp_nxt      = r_exp;
        w_done_nxt     = 1'b0;
        w_pass_nxt     = r_pass;
        w_fail_idx_nxt = r_fail_idx;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt    = S_RUN;
                    w_vec_nxt      = '0;
                    w_dwell_nxt    = '0;
                    w_table_nxt    = '0;
                    w_pass_nxt     = 1'b0;
                    w_fail_idx_nxt = '0;
                    w_exp_nxt      = expected;
                end
            end
            S_RUN: begin
                if (abort) begin
                    w_state_nxt = S_IDLE;
                    w_vec_nxt   = '0;
                    w_dwell_nxt = '0;
                    w_pass_nxt  = 1'b0;
                end else if (r_dwell < DW_LAST) begin
                    w_dwell_nxt = r_dwell + 8'd1;
                end else begin
                    w_dwell_nxt = '0;
                    w_table_nxt = w_table_smp;
                    if (r_vec == VEC_LAST) begin
                        w_state_nxt    = S_IDLE;
                        w_vec_nxt      = '0;
                        w_done_nxt     = 1'b1;
                        w_pass_nxt     = (w_diff == '0);
                        w_fail_idx_nxt = w_first_miss;
                    end else begin
                        w_vec_nxt = r_vec + 1'b1;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_vec      <= '0;
            r_dwell    <= '0;
            r_table    <= '0;
            r_exp      <= '0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail_idx <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_vec      <= w_vec_nxt;
            r_dwell    <= w_dwell_nxt;
            r_table    <= w_table_nxt;
            r_exp      <= w_exp_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_fail_idx <= w_fail_idx_nxt;
        end
    end

    assign vec_o    = r_vec;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign table_o  = r_table;
    assign pass     = r_pass;
    assign fail_idx = r_fail_idx;

endmodule

// File: tb/tb_exp_sweep_ctrl.sv
// tb/tb_exp_sweep_ctrl.sv - scoreboard bench for exp_sweep_ctrl
module tb_exp_sweep_ctrl;

    typedef struct {
        logic [7:0] tbl;
        logic       pass;
        logic [2:0] fidx;
    } sb_t;

    sb_t sb[$];
    int  n_run  = 0;
    int  n_fail = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, abort = 1'b0;
    logic [7:0] expected = 8'h00;
    logic [2:0] vec_o, fail_idx;
    logic       y_i, busy, done, pass;
    logic [7:0] table_o;

    logic       start1 = 1'b0, abort1 = 1'b0;
    logic [7:0] expected1 = 8'h00;
    logic [2:0] vec1, fidx1;
    logic       y1, busy1, done1, pass1;
    logic [7:0] table1;

    always #5 clk = ~clk;

    function automatic logic golden(input logic [2:0] v);
        return (~v[2] & ~v[1]) | (~v[2] & v[1] & ~v[0]) | (v[2] & v[1] & v[0]);
    endfunction

    function automatic logic [7:0] golden_tbl();
        logic [7:0] t;
        for (int i = 0; i < 8; i++) t[i] = golden(3'(i));
        return t;
    endfunction

    function automatic sb_t model(input logic [7:0] obs, input logic [7:0] exp_t);
        sb_t r;
        r.tbl  = obs;
        r.pass = (obs == exp_t);
        r.fidx = 3'd0;
        for (int i = 7; i >= 0; i--) if (obs[i] != exp_t[i]) r.fidx = 3'(i);
        return r;
    endfunction

    assign y_i = golden(vec_o);
    assign y1  = 1'b1;

    exp_sweep_ctrl #(.N_IN(3), .DWELL(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .vec_o(vec_o), .y_i(y_i), .busy(busy), .done(done), .table_o(table_o),
        .pass(pass), .fail_idx(fail_idx)
    );

    exp_sweep_ctrl #(.N_IN(3), .DWELL(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .expected(expected1),
        .vec_o(vec1), .y_i(y1), .busy(busy1), .done(done1), .table_o(table1),
        .pass(pass1), .fail_idx(fidx1)
    );

    task automatic test_reset();
        #2;
        n_run++;
        if ({busy, done, vec_o, table_o, pass, fail_idx, busy1, done1, table1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b vec=%0d tbl=%h pass=%b fidx=%0d (dut1 busy=%b tbl=%h) required all 0",
                     busy, done, vec_o, table_o, pass, fail_idx, busy1, table1);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sweep(input string nm, input logic [7:0] exp_t);
        sb_t got, want;
        int  e;
        bit  seen, trace_bad;
        sb.push_back(model(golden_tbl(), exp_t));
        @(negedge clk);
        expected = exp_t;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        expected = ~exp_t;
        e = 0; seen = 0; trace_bad = 0;
        while (!seen && e < 100) begin
            if (e < 16 && (busy !== 1'b1 || done !== 1'b0 || vec_o !== 3'(e / 2))) begin
                if (!trace_bad) begin
                    n_fail++;
                    $display("FAIL %s_trace: edge %0d busy=%b done=%b vec=%0d required busy=1 done=0 vec=%0d",
                             nm, e, busy, done, vec_o, e / 2);
                end
                trace_bad = 1;
            end
            if (done === 1'b1) begin
                seen = 1;
            end else begin
                @(negedge clk);
                e++;
            end
        end
        n_run++;
        n_run++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within 100 cycles", nm);
        end else begin
            want = sb.pop_front();
            got  = '{table_o, pass, fail_idx};
            if (e != 16) begin
                n_fail++;
                $display("FAIL %s_latency: done after %0d edges required 16", nm, e);
            end
            n_run++;
            if (got.tbl !== want.tbl || got.pass !== want.pass || got.fidx !== want.fidx) begin
                n_fail++;
                $display("FAIL %s_result: tbl=%h pass=%b fidx=%0d required tbl=%h pass=%b fidx=%0d",
                         nm, got.tbl, got.pass, got.fidx, want.tbl, want.pass, want.fidx);
            end
            @(negedge clk);
            n_run++;
            if (done !== 1'b0 || busy !== 1'b0 || table_o !== want.tbl) begin
                n_fail++;
                $display("FAIL %s_after: done=%b busy=%b tbl=%h required done=0 busy=0 tbl=%h",
                         nm, done, busy, table_o, want.tbl);
            end
        end
    endtask

    task automatic test_back_to_back();
        sb_t want;
        int  low_cnt;
        sb.push_back(model(golden_tbl(), 8'h87));
        sb.push_back(model(golden_tbl(), 8'h87));
        @(negedge clk);
        expected = 8'h87;
        start    = 1'b1;
        low_cnt  = 0;
        for (int e = 0; e <= 34; e++) begin
            @(negedge clk);
            if (e >= 1 && e <= 32 && busy === 1'b0) low_cnt++;
            if (e == 16 || e == 33) begin
                n_run++;
                want = sb.pop_front();
                if (done !== 1'b1 || busy !== 1'b0 || table_o !== want.tbl || pass !== want.pass) begin
                    n_fail++;
                    $display("FAIL b2b_done_e%0d: done=%b busy=%b tbl=%h pass=%b required done=1 busy=0 tbl=%h pass=%b",
                             e, done, busy, table_o, pass, want.tbl, want.pass);
                end
            end
            if (e == 17) begin
                n_run++;
                if (busy !== 1'b1 || done !== 1'b0 || table_o !== 8'h00) begin
                    n_fail++;
                    $display("FAIL b2b_restart: busy=%b done=%b tbl=%h required busy=1 done=0 tbl=00",
                             busy, done, table_o);
                end
            end
            if (e == 20) start = 1'b0;
        end
        n_run++;
        if (low_cnt != 1) begin
            n_fail++;
            $display("FAIL b2b_gap: busy low %0d cycles between sweeps required 1", low_cnt);
        end
    endtask

    task automatic test_abort();
        int done_cnt;
        @(negedge clk);
        expected = 8'h87;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        n_run++;
        if (busy !== 1'b0 || vec_o !== 3'd0 || done !== 1'b0 || pass !== 1'b0 || table_o !== 8'h03) begin
            n_fail++;
            $display("FAIL abort_state: busy=%b vec=%0d done=%b pass=%b tbl=%h required busy=0 vec=0 done=0 pass=0 tbl=03",
                     busy, vec_o, done, pass, table_o);
        end
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_run++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: %0d cycles with done/busy after abort required 0", done_cnt);
        end
        test_sweep("post_abort", 8'h87);
    endtask

    task automatic test_async_reset();
        int done_cnt;
        @(negedge clk);
        expected = 8'h87;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        n_run++;
        if (table_o !== 8'h07 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_partial: tbl=%h busy=%b required tbl=07 busy=1", table_o, busy);
        end
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if ({busy, done, vec_o, table_o, pass, fail_idx} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: busy=%b done=%b vec=%0d tbl=%h pass=%b fidx=%0d required all 0",
                     busy, done, vec_o, table_o, pass, fail_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        n_run++;
        if (done_cnt != 0) begin
            n_fail++;
            $display("FAIL rst_quiet: %0d cycles with done/busy after reset required 0", done_cnt);
        end
    endtask

    task automatic test_dwell1();
        sb_t want;
        int  e;
        bit  seen, trace_bad;
        sb.push_back(model(8'hFF, 8'hFF));
        @(negedge clk);
        expected1 = 8'hFF;
        start1    = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        e = 0; seen = 0; trace_bad = 0;
        while (!seen && e < 100) begin
            if (e < 8 && (busy1 !== 1'b1 || vec1 !== 3'(e))) begin
                if (!trace_bad) begin
                    n_fail++;
                    $display("FAIL dw1_trace: edge %0d busy=%b vec=%0d required busy=1 vec=%0d", e, busy1, vec1, e);
                end
                trace_bad = 1;
            end
            if (done1 === 1'b1) begin
                seen = 1;
            end else begin
                if (e == 2) start1 = 1'b1;
                @(negedge clk);
                start1 = 1'b0;
                e++;
            end
        end
        n_run++;
        n_run++;
        if (!seen) begin
            n_fail++;
            $display("FAIL dw1_timeout: no done within 100 cycles");
        end else begin
            want = sb.pop_front();
            if (e != 8) begin
                n_fail++;
                $display("FAIL dw1_latency: done after %0d edges required 8", e);
            end
            n_run++;
            if (table1 !== want.tbl || pass1 !== want.pass || fidx1 !== want.fidx) begin
                n_fail++;
                $display("FAIL dw1_result: tbl=%h pass=%b fidx=%0d required tbl=%h pass=%b fidx=%0d",
                         table1, pass1, fidx1, want.tbl, want.pass, want.fidx);
            end
            @(negedge clk);
            n_run++;
            if (busy1 !== 1'b0 || done1 !== 1'b0) begin
                n_fail++;
                $display("FAIL dw1_ignored_start: busy=%b done=%b required busy=0 done=0", busy1, done1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep("golden", 8'h87);
        test_sweep("mismatch", 8'h8F);
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_dwell1();
        n_run++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/exp_sweep_ctrl.md
Name: exp_sweep_ctrl

Overview:
- Sequencer that drives every input combination of a small combinational boolean-expression block and samples its output.
- Assembles the observed truth table, compares it against an expected table, and reports pass/fail plus the index of the first mismatch.
- Sits beside the expression datapath as its self-check/characterisation controller, replacing a hand-stepped stimulus sequence with a start/busy/done handshake.

Parameters:
- N_IN, 3, number of datapath inputs; truth-table width TW = 2**N_IN.
- DWELL, 2, clock cycles each input vector is held before y is sampled; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a sweep; sampled on the clk edge, honoured only in IDLE.
- abort  input  1  terminate a sweep in progress; honoured only in RUN.
- expected  input  TW  expected truth table; bit i is the expected y for vector i. Latched on start acceptance.
- vec_o  output  N_IN  vector driven to the datapath. vec_o[N_IN-1] is the MSB input (a); for N_IN=3, {a,b,c} = vec_o[2:0].
- y_i  input  1  datapath output, combinational from vec_o.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when a sweep completes normally.
- table_o  output  TW  observed truth table; holds its value until the next accepted start.
- pass  output  1  table_o == latched expected; valid from done until the next start.
- fail_idx  output  N_IN  lowest index i with table_o[i] != expected[i]; 0 when pass=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE; vec_o, busy, done, pass, table_o, fail_idx, dwell counter and latched expected all 0.
- States: IDLE and RUN only. done is a registered pulse, not a separate state.
- IDLE + start=1 at an edge:
  - go to RUN; busy=1; vec_o=0; dwell_cnt=0; table_o=0; pass=0; fail_idx=0; expected latched.
- RUN, each edge:
  - If abort=1: go to IDLE; busy=0; vec_o=0; pass=0; done stays 0; table_o keeps its partial contents. Abort has priority over sampling.
  - Else if dwell_cnt < DWELL-1: dwell_cnt++.
  - Else sample: table_o[vec_o] <= y_i; dwell_cnt <= 0.
    - If vec_o == TW-1: go to IDLE; busy=0; vec_o=0; done=1 for exactly one cycle. pass and fail_idx are computed on the completed table, including the final sample taken on this edge.
    - Otherwise: vec_o++.
- Timing: each vector is held exactly DWELL cycles. y_i is captured on the last edge of each hold.
- Latency: if start is accepted at edge k, done is high during the cycle after edge k + TW*DWELL. With defaults, busy stays high for 16 cycles.
- start while busy is ignored. start asserted in the same cycle that done is high is accepted, because the FSM is already in IDLE.
- expected may change freely during RUN without effect.
- vec_o does not wrap within a sweep; it counts 0..TW-1 once.
- fail_idx uses a priority encoder, lowest index wins.
- rst_n asserted mid-sweep: immediate return to reset values; no done pulse.

Test Plan:
- Golden datapath y = ~a&~b | ~a&b&~c | a&b&c (table 8'h87), expected=8'h87, DWELL=2, pulse start -> vec_o steps 0..7 every 2 cycles; done pulse 16 cycles after start; table_o=8'h87, pass=1, fail_idx=0.
- Same datapath, expected=8'h8F -> done after 16 cycles; table_o=8'h87, pass=0, fail_idx=3.
- Start held high continuously through a sweep -> second sweep begins the cycle done is high; busy low for exactly one cycle between sweeps; both sweeps report 8'h87.
- abort pulsed 5 cycles after start -> busy falls next edge; vec_o=0; no done; pass=0; a subsequent start completes normally.
- rst_n pulsed low mid-sweep (asynchronously, between edges) -> all outputs 0 immediately; no done.
- DWELL=1 with datapath tied y=1, expected=8'hFF -> done 8 cycles after start; pass=1; start while busy is ignored, verified by an extra pulse at cycle 3.
